mar_banked: RTL and testbench

Parametrised memory address register for the SAP-2/SAP-3 datapath, successor to the 4-bit SAP-1 MAR. It assembles an ADDR_W-bit address from a narrower BUS_W-bit W-bus over several load cycles, committing the whole address in one step so memory never sees a half-written address. It also supports in-place increment for sequential fetches. It sits between the W-bus and the RAM address port.

---
 rtl/mar_pkg.sv | 23 ++
 rtl/mar_chunk_stager.sv | 72 +++++++
 rtl/mar_banked.sv | 76 +++++++
 tb/tb_mar_banked.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mar_pkg.sv
// Shared types and sizing helpers for the banked memory address register.
// Imported by mar_chunk_stager and mar_banked.
package mar_pkg;

    typedef enum logic {
        MAR_IDLE = 1'b0,
        MAR_FILL = 1'b1
    } mar_state_t;

    localparam int MAR_MIN_IDX_W = 1;

    function automatic int nchunk(input int addr_w, input int bus_w);
        return (addr_w + bus_w - 1) / bus_w;
    endfunction

    // A single-chunk build still needs a 1-bit index so the ports stay legal.
    function automatic int idx_width(input int n);
        int w;
        w = $clog2(n);
        return (w < MAR_MIN_IDX_W) ? MAR_MIN_IDX_W : w;
    endfunction

endpackage

// File: rtl/mar_chunk_stager.sv
// Collects LSB-first W-bus chunks into a staging register and flags the
// cycle in which the final chunk arrives so the top level can commit it.
module mar_chunk_stager
    import mar_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int BUS_W  = 8
) (
    input  logic              clk_i,
    input  logic              clr_i,
    input  logic [BUS_W-1:0]  chunk_i,
    input  logic              load_n_i,
    output logic              commit_o,
    output logic              busy_o,
    output logic [ADDR_W-1:0] addr_o
);

    localparam int NCHUNK = nchunk(ADDR_W, BUS_W);
    localparam int IDX_W  = idx_width(NCHUNK);
    localparam int STG_W  = (NCHUNK > 1) ? (NCHUNK - 1) * BUS_W : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    mar_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [STG_W-1:0] stg_q, stg_d;

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            state_q <= MAR_IDLE;
            idx_q   <= '0;
            stg_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            stg_q   <= stg_d;
        end
    end

    // Index is 0 whenever idle, so the same compare covers both states.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        stg_d    = stg_q;
        commit_o = 1'b0;
        if (!load_n_i) begin
            if (idx_q == LAST_IDX) begin
                commit_o = 1'b1;
                idx_d    = '0;
                state_d  = MAR_IDLE;
            end else begin
                for (int k = 0; k < NCHUNK - 1; k++) begin
                    if (idx_q == IDX_W'(k)) begin
                        stg_d[k*BUS_W +: BUS_W] = chunk_i;
                    end
                end
                idx_d   = idx_q + IDX_W'(1);
                state_d = MAR_FILL;
            end
        end
    end

    assign busy_o = (state_q == MAR_FILL);

    generate
        if (NCHUNK > 1) begin : g_multi
            assign addr_o = ADDR_W'({chunk_i, stg_q});
        end else begin : g_single
            assign addr_o = chunk_i;
        end
    endgenerate

endmodule

// File: rtl/mar_banked.sv
// Memory address register fed chunk-wise from the W-bus, with increment.
// Optional feature macro: MAR_WRAP_FLAG_EN adds the mar_wrap pulse output.
module mar_banked
    import mar_pkg::*;
#(
    parameter int                ADDR_W     = 16,
    parameter int                BUS_W      = 8,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic [BUS_W-1:0]  mar_input,
    input  logic              Lm_bar,
    input  logic              Im_bar,
`ifdef MAR_WRAP_FLAG_EN
    output logic              mar_wrap,
`endif
    output logic [ADDR_W-1:0] mar_output,
    output logic              mar_busy
);

    logic              commit;
    logic [ADDR_W-1:0] assembled;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic              incr;

    mar_chunk_stager #(
        .ADDR_W (ADDR_W),
        .BUS_W  (BUS_W)
    ) u_stager (
        .clk_i    (CLK),
        .clr_i    (CLR),
        .chunk_i  (mar_input),
        .load_n_i (Lm_bar),
        .commit_o (commit),
        .busy_o   (mar_busy),
        .addr_o   (assembled)
    );

    // A commit in the same cycle as an increment request takes priority.
    assign incr = !Im_bar && !commit;

    always_comb begin
        mar_d = mar_q;
        if (commit) begin
            mar_d = assembled;
        end else if (incr) begin
            mar_d = mar_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            mar_q <= RESET_ADDR;
        end else begin
            mar_q <= mar_d;
        end
    end

    assign mar_output = mar_q;

`ifdef MAR_WRAP_FLAG_EN
    logic wrap_q;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= incr && (&mar_q);
        end
    end

    assign mar_wrap = wrap_q;
`endif

endmodule

// File: tb/tb_mar_banked.sv
// Directed bench for mar_banked: 16/8 default instance plus a 12/8 instance.
// Wrap-flag checks are compiled in when MAR_WRAP_FLAG_EN is defined.
module tb_mar_banked;

    logic        CLK = 1'b0;
    logic        CLR = 1'b1;
    logic [7:0]  dIn = 8'h00;
    logic        lmBar = 1'b1;
    logic        imBar = 1'b1;
    logic [15:0] marOut;
    logic        marBusy;

    logic [7:0]  nIn = 8'h00;
    logic        nLmBar = 1'b1;
    logic        nImBar = 1'b1;
    logic [11:0] nOut;
    logic        nBusy;

`ifdef MAR_WRAP_FLAG_EN
    logic        marWrap;
    logic        nWrap;
`endif

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    mar_banked #(
        .ADDR_W     (16),
        .BUS_W      (8),
        .RESET_ADDR (16'h0000)
    ) dut (
        .CLK        (CLK),
        .CLR        (CLR),
        .mar_input  (dIn),
        .Lm_bar     (lmBar),
        .Im_bar     (imBar),
`ifdef MAR_WRAP_FLAG_EN
        .mar_wrap   (marWrap),
`endif
        .mar_output (marOut),
        .mar_busy   (marBusy)
    );

    mar_banked #(
        .ADDR_W     (12),
        .BUS_W      (8),
        .RESET_ADDR (12'h000)
    ) dutNarrow (
        .CLK        (CLK),
        .CLR        (CLR),
        .mar_input  (nIn),
        .Lm_bar     (nLmBar),
        .Im_bar     (nImBar),
`ifdef MAR_WRAP_FLAG_EN
        .mar_wrap   (nWrap),
`endif
        .mar_output (nOut),
        .mar_busy   (nBusy)
    );

    // Drive one cycle of inputs on the main instance, then sample 1 ns after the edge.
    task automatic applyStimulus(input logic clr, input logic lm, input logic im, input logic [7:0] d);
        CLR   = clr;
        lmBar = lm;
        imBar = im;
        dIn   = d;
        @(posedge CLK);
        #1;
        CLR   = 1'b0;
        lmBar = 1'b1;
        imBar = 1'b1;
    endtask

    task automatic applyNarrow(input logic lm, input logic im, input logic [7:0] d);
        nLmBar = lm;
        nImBar = im;
        nIn    = d;
        @(posedge CLK);
        #1;
        nLmBar = 1'b1;
        nImBar = 1'b1;
    endtask

    task automatic test_reset();
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h55);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h55);
        checks++;
        if (marOut !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL reset_out: got %h expected %h", marOut, 16'h0000);
        end
        checks++;
        if (marBusy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_busy: got %b expected %b", marBusy, 1'b0);
        end
        checks++;
        if (nOut !== 12'h000) begin
            errors++;
            $display("[TB] FAIL reset_narrow_out: got %h expected %h", nOut, 12'h000);
        end
`ifdef MAR_WRAP_FLAG_EN
        checks++;
        if (marWrap !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_wrap: got %b expected %b", marWrap, 1'b0);
        end
`endif
    endtask

    task automatic test_two_chunk();
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h34);
        checks++;
        if (marOut !== 16'h0000 || marBusy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL two_chunk_edge1: got out=%h busy=%b expected out=0000 busy=1", marOut, marBusy);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h12);
        checks++;
        if (marOut !== 16'h1234 || marBusy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL two_chunk_edge2: got out=%h busy=%b expected out=1234 busy=0", marOut, marBusy);
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 8'hFF);
        checks++;
        if (marOut !== 16'h1234) begin
            errors++;
            $display("[TB] FAIL two_chunk_hold: got %h expected %h", marOut, 16'h1234);
        end
    endtask

    task automatic test_pause_increment();
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h10);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        checks++;
        if (marOut !== 16'h0010) begin
            errors++;
            $display("[TB] FAIL pause_preload: got %h expected %h", marOut, 16'h0010);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h78);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 8'hEE);
        end
        checks++;
        if (marOut !== 16'h0013 || marBusy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pause_incr: got out=%h busy=%b expected out=0013 busy=1", marOut, marBusy);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h56);
        checks++;
        if (marOut !== 16'h5678 || marBusy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pause_resume: got out=%h busy=%b expected out=5678 busy=0", marOut, marBusy);
        end
    endtask

    task automatic test_wrap();
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hFF);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hFF);
        checks++;
        if (marOut !== 16'hFFFF) begin
            errors++;
            $display("[TB] FAIL wrap_preload: got %h expected %h", marOut, 16'hFFFF);
        end
`ifdef MAR_WRAP_FLAG_EN
        checks++;
        if (marWrap !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wrap_on_load: got %b expected %b", marWrap, 1'b0);
        end
`endif
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checks++;
        if (marOut !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL wrap_value: got %h expected %h", marOut, 16'h0000);
        end
`ifdef MAR_WRAP_FLAG_EN
        checks++;
        if (marWrap !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wrap_pulse: got %b expected %b", marWrap, 1'b1);
        end
`endif
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h00);
`ifdef MAR_WRAP_FLAG_EN
        checks++;
        if (marWrap !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wrap_pulse_end: got %b expected %b", marWrap, 1'b0);
        end
`endif
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        checks++;
        if (marOut !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL wrap_zero_load: got %h expected %h", marOut, 16'h0000);
        end
`ifdef MAR_WRAP_FLAG_EN
        checks++;
        if (marWrap !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wrap_zero_load_flag: got %b expected %b", marWrap, 1'b0);
        end
`endif
    endtask

    task automatic test_reset_midload();
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h34);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h12);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hAA);
        checks++;
        if (marBusy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midload_busy: got %b expected %b", marBusy, 1'b1);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h77);
        checks++;
        if (marOut !== 16'h0000 || marBusy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midload_reset: got out=%h busy=%b expected out=0000 busy=0", marOut, marBusy);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h01);
        checks++;
        if (marOut !== 16'h0000 || marBusy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midload_restart: got out=%h busy=%b expected out=0000 busy=1", marOut, marBusy);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        checks++;
        if (marOut !== 16'h0001 || marBusy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midload_commit: got out=%h busy=%b expected out=0001 busy=0", marOut, marBusy);
        end
    endtask

    task automatic test_back_to_back();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'hEF);
        checks++;
        if (marOut !== 16'h0002 || marBusy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL collide_first: got out=%h busy=%b expected out=0002 busy=1", marOut, marBusy);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 8'hBE);
        checks++;
        if (marOut !== 16'hBEEF) begin
            errors++;
            $display("[TB] FAIL collide_commit: got %h expected %h", marOut, 16'hBEEF);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checks++;
        if (marOut !== 16'hBEF1) begin
            errors++;
            $display("[TB] FAIL sustained_incr: got %h expected %h", marOut, 16'hBEF1);
        end
    endtask

    task automatic test_narrow();
        applyNarrow(1'b0, 1'b1, 8'hCD);
        checks++;
        if (nOut !== 12'h000 || nBusy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL narrow_edge1: got out=%h busy=%b expected out=000 busy=1", nOut, nBusy);
        end
        applyNarrow(1'b0, 1'b1, 8'hAB);
        checks++;
        if (nOut !== 12'hBCD || nBusy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL narrow_commit: got out=%h busy=%b expected out=BCD busy=0", nOut, nBusy);
        end
        applyNarrow(1'b0, 1'b1, 8'hFF);
        applyNarrow(1'b0, 1'b1, 8'hFF);
        checks++;
        if (nOut !== 12'hFFF) begin
            errors++;
            $display("[TB] FAIL narrow_allones: got %h expected %h", nOut, 12'hFFF);
        end
        applyNarrow(1'b1, 1'b0, 8'h00);
        checks++;
        if (nOut !== 12'h000) begin
            errors++;
            $display("[TB] FAIL narrow_wrap: got %h expected %h", nOut, 12'h000);
        end
`ifdef MAR_WRAP_FLAG_EN
        checks++;
        if (nWrap !== 1'b1) begin
            errors++;
            $display("[TB] FAIL narrow_wrap_pulse: got %b expected %b", nWrap, 1'b1);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_two_chunk();
        test_pause_increment();
        test_wrap();
        test_reset_midload();
        test_back_to_back();
        test_narrow();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
